dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 The module SHALL use the following ports (clock and reset first).
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- dcache_raddr_i  in  32  CPU read byte address
- dcache_rreq_i  in  1  CPU read request
- dcache_waddr_i  in  32  CPU write byte address
- dcache_wdata_i  in  32  CPU write data
- dcache_wreq_i  in  1  CPU write request
- dcache_sel_i  in  4  byte enables; bit n selects data[8n+7:8n]
- dcache_data_o  out  32  read data to CPU
- dcache_stall_o  out  1  CPU must hold its request while high
- mem_rreq_o  out  1  refill burst request
- mem_raddr_o  out  32  refill line address; offset bits [3:0] are zero
- mem_rvalid_i  in  1  one refill word valid
- mem_rdata_i  in  32  refill word; beats arrive in ascending word order 0..3
- mem_wreq_o  out  1  write-through request
- mem_waddr_o  out  32  write-through address
- mem_wdata_o  out  32  write-through data
- mem_wsel_o  out  4  write-through byte enables
- mem_wready_i  in  1  memory accepts the write-through this cycle

REQ-002 Parameters:
- SETS, default 256, number of sets
- WORDS, default 4, words per line

Function
REQ-003 Organisation SHALL be direct-mapped with 16-byte lines.
- Address fields: tag [31:12], index [11:4], word [3:2].
- Arrays: valid bit, 20-bit tag and 4 data words per set.

REQ-004 Read hit SHALL be zero-latency: dcache_data_o = selected word, combinational, in the same cycle rreq is high; dcache_stall_o stays low.

REQ-005 Write policy SHALL be write-through, no-write-allocate.
- Write hit: merges the sel'd bytes into the line at the clock edge.
- Write miss: leaves the arrays untouched.
- Every write loads the 1-entry write buffer.

REQ-006 Write buffer behaviour:
- When full, it drives mem_wreq_o=1 with the buffered addr/data/sel.
- It empties on the edge where mem_wready_i=1.
- A new write while the buffer is full and not draining this cycle SHALL assert dcache_stall_o and is accepted only once a slot is free.

REQ-007 Same-cycle read and write:
- Both SHALL be accepted in the same cycle.
- If they address the same word, dcache_data_o SHALL return the byte-merged new data (bypass).

REQ-008 FSM states:
- IDLE -> DRAIN on a read miss with the write buffer non-empty.
- IDLE -> REFILL on a read miss with the buffer empty.
- DRAIN -> REFILL when the buffer empties.
- REFILL -> RESP after the 4th mem_rvalid_i beat.
- RESP -> IDLE after one cycle.

REQ-009 In DRAIN and REFILL, dcache_stall_o SHALL be 1.

REQ-010 In REFILL, mem_rreq_o=1 and mem_raddr_o={raddr[31:4],4'b0}.
- A 2-bit beat counter writes each beat to the data array.
- Tag and valid are written with the 4th beat.

REQ-011 In RESP, dcache_stall_o=0 and dcache_data_o SHALL equal the requested word from the new line.
- If a write to that word is also accepted in RESP, the merged value is returned.

REQ-012 mem_rvalid_i outside REFILL SHALL be ignored.

REQ-013 dcache_data_o SHALL be 0 when no read is requested or while stalled.

REQ-014 Request inputs SHALL be held stable by the CPU while dcache_stall_o=1.
- A miss address change during REFILL is not supported; the captured address is used.

Reset
REQ-015 On rst=1, asynchronously:
- all valid bits = 0; FSM = IDLE; beat counter = 0; write buffer empty;
- all outputs = 0 (dcache_stall_o, mem_rreq_o, mem_wreq_o, all addr/data/sel).

REQ-016 rst asserted mid-REFILL or mid-DRAIN SHALL abandon the operation with no partial line marked valid; the pending buffered write is dropped.

Verification
REQ-017 Cold read of 0x00000010 with memory words 0xA0..0xA3 at 0x10..0x1C:
- stall for 4 beats plus DRAIN cycles, then data_o=0xA0 in RESP.
- An immediate re-read of 0x14 hits with 0 stall and returns 0xA1.

REQ-018 Write 0x0000BEEF, sel=1111, to 0x20 on a cold cache (miss):
- mem_wreq_o=1 with addr 0x20 until wready.
- A following read of 0x20 drains, then refills and returns 0x0000BEEF from memory.

REQ-019 Write hit to a cached word 0x11223344 with sel=0010 and data 0x0000AA00:
- array word becomes 0x1122AA44.
- A same-cycle read of that word returns 0x1122AA44 (bypass).

REQ-020 Write buffer full with wready=0 and a second write arriving:
- stall_o=1 until wready pulses.
- Then the second write is accepted and mem_waddr_o switches to it.

REQ-021 Assert rst after the 2nd refill beat:
- outputs all 0 immediately.
- A later read of the same line misses and refills all 4 beats.

REQ-022 Conflict at 0x00001010 after 0x00000010 is cached (same index, different tag):
- miss and refill; the old line is replaced.
- A read of 0x10 then misses again.

Source files
------------

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data cache with one-entry write buffer and line refill
module dcache_responder #(
  parameter int SETS  = 256,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_raddr_i,
  input  logic        dcache_rreq_i,
  input  logic [31:0] dcache_waddr_i,
  input  logic [31:0] dcache_wdata_i,
  input  logic        dcache_wreq_i,
  input  logic [3:0]  dcache_sel_i,
  output logic [31:0] dcache_data_o,
  output logic        dcache_stall_o,
  output logic        mem_rreq_o,
  output logic [31:0] mem_raddr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_wreq_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wsel_o,
  input  logic        mem_wready_i
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WRD_W  = $clog2(WORDS);
  localparam int OFF_W  = WRD_W + 2;
  localparam int IDX_LO = OFF_W;
  localparam int TAG_LO = OFF_W + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_REFILL,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  // Cache arrays: valid bits need reset, tag/data are plain storage.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][WORDS];

  // Captured miss address and refill beat position.
  logic [31:0]      miss_addr;
  logic [WRD_W-1:0] beat;

  // One-entry write-through buffer.
  logic             wb_valid;
  logic [31:0]      wb_addr;
  logic [31:0]      wb_data;
  logic [3:0]       wb_sel;

  // Read lookup fields.
  logic [31:0]      lk_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [WRD_W-1:0] lk_wrd;
  logic             rd_hit;
  logic [31:0]      rd_word;

  // Write lookup fields.
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WRD_W-1:0] w_wrd;
  logic             wr_hit;
  logic [31:0]      wr_merged;

  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic             refill_beat;
  logic             refill_last;
  logic             wb_stall;
  logic             miss_stall;
  logic             stall;
  logic             wr_accept;
  logic             miss_capture;
  logic             same_word;
  logic [31:0]      rd_data;
  logic             unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  // In RESP the CPU address is held, but the captured address is the authoritative one.
  assign lk_addr  = (state == S_RESP) ? miss_addr : dcache_raddr_i;
  assign lk_idx   = lk_addr[IDX_LO +: IDX_W];
  assign lk_tag   = lk_addr[TAG_LO +: TAG_W];
  assign lk_wrd   = lk_addr[2 +: WRD_W];
  assign rd_hit   = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign rd_word  = data_mem[lk_idx][lk_wrd];

  assign w_idx     = dcache_waddr_i[IDX_LO +: IDX_W];
  assign w_tag     = dcache_waddr_i[TAG_LO +: TAG_W];
  assign w_wrd     = dcache_waddr_i[2 +: WRD_W];
  assign wr_hit    = valid_q[w_idx] && (tag_mem[w_idx] == w_tag);
  assign wr_merged = merge_bytes(data_mem[w_idx][w_wrd], dcache_wdata_i, dcache_sel_i);

  assign miss_idx  = miss_addr[IDX_LO +: IDX_W];
  assign miss_tag  = miss_addr[TAG_LO +: TAG_W];

  assign refill_beat = (state == S_REFILL) && mem_rvalid_i;
  assign refill_last = refill_beat && (beat == LAST_BEAT);

  // A write may replace the buffered one on the same edge the buffer drains.
  assign wb_stall  = dcache_wreq_i && wb_valid && !mem_wready_i;
  assign same_word = (lk_addr[31:2] == dcache_waddr_i[31:2]);

  assign unused_addr_bits = ^{lk_addr[1:0], dcache_waddr_i[1:0]};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, refill request, stall and read data selection.
  always_comb begin
    state_nxt    = state;
    miss_stall   = 1'b0;
    miss_capture = 1'b0;
    mem_rreq_o   = 1'b0;
    mem_raddr_o  = '0;
    rd_data      = '0;
    case (state)
      S_IDLE: begin
        if (dcache_rreq_i && !rd_hit) begin
          miss_stall   = 1'b1;
          miss_capture = 1'b1;
          state_nxt    = wb_valid ? S_DRAIN : S_REFILL;
        end
      end
      S_DRAIN: begin
        miss_stall = 1'b1;
        if (!wb_valid || mem_wready_i) begin
          state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        miss_stall  = 1'b1;
        mem_rreq_o  = 1'b1;
        mem_raddr_o = {miss_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (refill_last) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    stall     = miss_stall || wb_stall;
    wr_accept = dcache_wreq_i && !stall;
    if (dcache_rreq_i && !stall && rd_hit) begin
      rd_data = (wr_accept && same_word) ? merge_bytes(rd_word, dcache_wdata_i, dcache_sel_i)
                                         : rd_word;
    end
  end

  // Combinational CPU-facing outputs are forced low while reset is held.
  assign dcache_stall_o = stall && !rst;
  assign dcache_data_o  = rst ? 32'h0 : rd_data;

  assign mem_wreq_o  = wb_valid;
  assign mem_waddr_o = wb_valid ? wb_addr : 32'h0;
  assign mem_wdata_o = wb_valid ? wb_data : 32'h0;
  assign mem_wsel_o  = wb_valid ? wb_sel  : 4'h0;

  // Capture the miss address and step the refill beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_addr <= '0;
      beat      <= '0;
    end else begin
      if (miss_capture) begin
        miss_addr <= dcache_raddr_i;
      end
      if (refill_beat) begin
        beat <= beat + WRD_W'(1);
      end else if (state != S_REFILL) begin
        beat <= '0;
      end
    end
  end

  // Line becomes valid only with its final beat, so an aborted refill leaves it invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (refill_last) begin
      valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data storage: refill beats and CPU write hits never coincide since writes stall during refill.
  always_ff @(posedge clk) begin
    if (refill_beat) begin
      data_mem[miss_idx][beat] <= mem_rdata_i;
    end
    if (refill_last) begin
      tag_mem[miss_idx] <= miss_tag;
    end
    if (wr_accept && wr_hit) begin
      data_mem[w_idx][w_wrd] <= wr_merged;
    end
  end

  // Write buffer: every accepted write loads it; it empties when memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_sel   <= '0;
    end else if (wr_accept) begin
      wb_valid <= 1'b1;
      wb_addr  <= dcache_waddr_i;
      wb_data  <= dcache_wdata_i;
      wb_sel   <= dcache_sel_i;
    end else if (wb_valid && mem_wready_i) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - scoreboard bench for dcache_responder
`timescale 1ns/1ps
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dcache_raddr_i;
  logic        dcache_rreq_i;
  logic [31:0] dcache_waddr_i;
  logic [31:0] dcache_wdata_i;
  logic        dcache_wreq_i;
  logic [3:0]  dcache_sel_i;
  logic [31:0] dcache_data_o;
  logic        dcache_stall_o;
  logic        mem_rreq_o;
  logic [31:0] mem_raddr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_wreq_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wsel_o;
  logic        mem_wready_i;

  dcache_responder #(.SETS(256), .WORDS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .dcache_raddr_i (dcache_raddr_i),
    .dcache_rreq_i  (dcache_rreq_i),
    .dcache_waddr_i (dcache_waddr_i),
    .dcache_wdata_i (dcache_wdata_i),
    .dcache_wreq_i  (dcache_wreq_i),
    .dcache_sel_i   (dcache_sel_i),
    .dcache_data_o  (dcache_data_o),
    .dcache_stall_o (dcache_stall_o),
    .mem_rreq_o     (mem_rreq_o),
    .mem_raddr_o    (mem_raddr_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_wreq_o     (mem_wreq_o),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wsel_o     (mem_wsel_o),
    .mem_wready_i   (mem_wready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd_q [$];
  wr_exp_t     wq [$];
  logic [31:0] mem_model [logic [31:0]];
  int          tb_beat   = 0;
  int          beats_acc = 0;
  bit          spurious  = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Memory refill responder: one beat per cycle while a refill is requested.
  always @(negedge clk) begin
    if (mem_rreq_o && tb_beat < 4) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_rd(mem_raddr_o + 32'(tb_beat * 4));
      tb_beat++;
    end else if (!mem_rreq_o && spurious) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADDEAD;
      tb_beat      = 0;
    end else begin
      mem_rvalid_i = 1'b0;
      if (!mem_rreq_o) tb_beat = 0;
    end
  end

  // Count refill beats actually taken by the cache.
  always @(posedge clk) begin
    if (mem_rreq_o && mem_rvalid_i) beats_acc++;
  end

  // Monitor: compares read data and write-through traffic against the queues.
  always @(negedge clk) begin
    logic [31:0] exp;
    wr_exp_t     e;
    logic [31:0] old;
    if (!rst && dcache_rreq_i && !dcache_stall_o) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h required no read", dcache_data_o);
      end else begin
        exp = rd_q.pop_front();
        if (dcache_data_o !== exp) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%08h required 0x%08h", dcache_data_o, exp);
        end
      end
    end
    if (!rst && mem_wreq_o && mem_wready_i) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wt_unexpected: got addr 0x%08h required no write", mem_waddr_o);
      end else begin
        e = wq.pop_front();
        if (mem_waddr_o !== e.addr || mem_wdata_o !== e.data || mem_wsel_o !== e.sel) begin
          n_fail++;
          $display("FAIL wt_beat: got %08h/%08h/%h required %08h/%08h/%h",
                   mem_waddr_o, mem_wdata_o, mem_wsel_o, e.addr, e.data, e.sel);
        end
        old = mem_rd(e.addr);
        for (int b = 0; b < 4; b++)
          if (e.sel[b]) old[8*b +: 8] = e.data[8*b +: 8];
        mem_model[e.addr] = old;
      end
    end
  end

  task automatic do_access(input bit rd, input logic [31:0] ra, input logic [31:0] rexp,
                           input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                           input logic [3:0] sel, output int stalls);
    bit      done;
    wr_exp_t e;
    stalls = 0;
    done   = 1'b0;
    if (rd) rd_q.push_back(rexp);
    if (wr) begin
      e.addr = wa;
      e.data = wd;
      e.sel  = sel;
      wq.push_back(e);
    end
    dcache_rreq_i  = rd;
    dcache_raddr_i = ra;
    dcache_wreq_i  = wr;
    dcache_waddr_i = wa;
    dcache_wdata_i = wd;
    dcache_sel_i   = sel;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!dcache_stall_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout: stalled %0d cycles, required release", stalls);
    end
    @(posedge clk);
    #1;
    dcache_rreq_i = 1'b0;
    dcache_wreq_i = 1'b0;
  endtask

  task automatic rd_only(input logic [31:0] a, input logic [31:0] exp, output int st);
    do_access(1'b1, a, exp, 1'b0, 32'h0, 32'h0, 4'h0, st);
  endtask

  task automatic wr_only(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int st);
    do_access(1'b0, 32'h0, 32'h0, 1'b1, a, d, s, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int b0;
    bit hit2;
    rst = 1'b1;
    dcache_raddr_i = '0; dcache_rreq_i = 1'b0; dcache_waddr_i = '0;
    dcache_wdata_i = '0; dcache_wreq_i = 1'b0; dcache_sel_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_wready_i = 1'b1;
    mem_model[32'h10] = 32'h000000A0;
    mem_model[32'h14] = 32'h000000A1;
    mem_model[32'h18] = 32'h000000A2;
    mem_model[32'h1C] = 32'h000000A3;
    mem_model[32'h44] = 32'h11223344;

    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'h0, dcache_stall_o}, 32'h0);
    check("rst_data",  dcache_data_o, 32'h0);
    check("rst_rreq",  {31'h0, mem_rreq_o}, 32'h0);
    check("rst_raddr", mem_raddr_o, 32'h0);
    check("rst_wreq",  {31'h0, mem_wreq_o}, 32'h0);
    check("rst_waddr", mem_waddr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_wsel",  {28'h0, mem_wsel_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then hits in the refilled line
    rd_only(32'h10, 32'hA0, st); check("cold_stall", st, 5);
    rd_only(32'h14, 32'hA1, st); check("hit_stall", st, 0);
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spurious = 1'b0;
    rd_only(32'h18, 32'hA2, st); check("hit2_stall", st, 0);
    rd_only(32'h1C, 32'hA3, st); check("hit3_stall", st, 0);

    // Write miss sits in the buffer, then a read of it drains before refilling
    mem_wready_i = 1'b0;
    wr_only(32'h20, 32'h0000BEEF, 4'hF, st); check("wmiss_stall", st, 0);
    for (int i = 0; i < 3; i++) begin
      check("wb_wreq", {31'h0, mem_wreq_o}, 32'h1);
      check("wb_waddr", mem_waddr_o, 32'h20);
      @(posedge clk);
      #1;
    end
    fork
      rd_only(32'h20, 32'h0000BEEF, st);
      begin
        repeat (3) @(posedge clk);
        #1;
        mem_wready_i = 1'b1;
      end
    join
    check("drain_stall", st, 8);

    // Write hit with byte merge and same-cycle bypass
    rd_only(32'h44, 32'h11223344, st); check("l40_stall", st, 5);
    do_access(1'b1, 32'h44, 32'h1122AA44, 1'b1, 32'h44, 32'h0000AA00, 4'b0010, st);
    check("bypass_stall", st, 0);
    rd_only(32'h44, 32'h1122AA44, st); check("merged_stall", st, 0);
    do_access(1'b1, 32'h40, 32'hC0DE0040, 1'b1, 32'h4C, 32'h12345678, 4'hF, st);
    check("rw_diff_stall", st, 0);
    rd_only(32'h4C, 32'h12345678, st);
    wr_only(32'h48, 32'hFFEEDDCC, 4'b1001, st);
    rd_only(32'h48, 32'hFFDE00CC, st);

    // Full buffer blocks a second write until memory accepts the first
    mem_wready_i = 1'b0;
    wr_only(32'h100, 32'h1, 4'hF, st); check("wbA_stall", st, 0);
    fork
      wr_only(32'h104, 32'h2, 4'hF, st);
      begin
        repeat (3) @(posedge clk);
        #1;
        mem_wready_i = 1'b1;
        @(posedge clk);
        #1;
        mem_wready_i = 1'b0;
      end
    join
    check("wbB_stall", st, 3);
    check("wbB_wreq", {31'h0, mem_wreq_o}, 32'h1);
    check("wbB_waddr", mem_waddr_o, 32'h104);
    check("wbB_wdata", mem_wdata_o, 32'h2);
    mem_wready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset after the second refill beat abandons the line
    b0 = beats_acc;
    hit2 = 1'b0;
    dcache_raddr_i = 32'h200;
    dcache_rreq_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (beats_acc - b0 == 2) begin
        hit2 = 1'b1;
        break;
      end
    end
    check("abort_reached", {31'h0, hit2}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_stall", {31'h0, dcache_stall_o}, 32'h0);
    check("abort_data",  dcache_data_o, 32'h0);
    check("abort_rreq",  {31'h0, mem_rreq_o}, 32'h0);
    check("abort_raddr", mem_raddr_o, 32'h0);
    check("abort_wreq",  {31'h0, mem_wreq_o}, 32'h0);
    dcache_rreq_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    b0 = beats_acc;
    rd_only(32'h200, 32'hC0DE0200, st); check("rerefill_stall", st, 5);
    check("rerefill_beats", 32'(beats_acc - b0), 32'h4);

    // Same index, different tag replaces the line
    rd_only(32'h10,   32'hA0,       st); check("conf_a_stall", st, 5);
    rd_only(32'h1010, 32'hC0DE1010, st); check("conf_b_stall", st, 5);
    rd_only(32'h10,   32'hA0,       st); check("conf_a2_stall", st, 5);
    rd_only(32'h14,   32'hA1,       st); check("conf_hit_stall", st, 0);

    for (int i = 0; i < 20; i++) begin
      if (rd_q.size() == 0 && wq.size() == 0) break;
      @(posedge clk);
    end
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    check("wq_empty",   32'(wq.size()),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
